// File: rtl/ddr3_app_responder.sv
// RAM-backed stand-in for the DDR3 controller user port: calibration delay,
// periodic refresh stalls, fixed read latency and in-order write pairing.
module ddr3_app_responder #(
  parameter int ADDR_WIDTH   = 29,
  parameter int DATA_WIDTH   = 256,
  parameter int MEM_AW       = 10,
  parameter int CALIB_CYCLES = 64,
  parameter int RD_LATENCY   = 4,
  parameter int REF_INTERVAL = 780,
  parameter int REF_CYCLES   = 16,
  parameter int WQ_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd,
  input  logic                    cmd_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  output logic                    wr_data_rdy,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_data_en,
  input  logic                    wr_data_end,
  input  logic [DATA_WIDTH/8-1:0] wr_data_mask,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_data_valid,
  output logic                    rd_data_end,
  output logic                    init_calib_complete,
  output logic                    protocol_err
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);
  localparam int REF_W  = $clog2(REF_INTERVAL + 1);
  localparam int RC_W   = $clog2(REF_CYCLES + 1);
  localparam int PW     = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int CW     = $clog2(WQ_DEPTH + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_REFRESH = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  ref_pend;
  logic                  ref_pend_nxt;
  logic [RC_W-1:0]       ref_cyc;
  logic [REF_W-1:0]      ref_cnt;
  logic                  ref_tick;
  logic                  ref_req;
  logic [CAL_W-1:0]      calib_cnt;
  logic [MEM_AW-1:0]     rd_idx;

  logic                  cmd_ok;
  logic                  cmd_acc;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wd_acc;
  logic                  launch;
  logic                  commit;
  logic                  err_now;
  logic                  addr_unused;

  logic [MEM_AW-1:0]     wcmd_mem [WQ_DEPTH];
  logic [PW-1:0]         wcmd_wptr;
  logic [PW-1:0]         wcmd_rptr;
  logic [CW-1:0]         wcmd_cnt;
  logic                  wcmd_full;
  logic                  wcmd_empty;

  logic [DATA_WIDTH-1:0] wdat_mem  [WQ_DEPTH];
  logic [MASK_W-1:0]     wmask_mem [WQ_DEPTH];
  logic [PW-1:0]         wdat_wptr;
  logic [PW-1:0]         wdat_rptr;
  logic [CW-1:0]         wdat_cnt;
  logic                  wdat_full;

  logic [DATA_WIDTH-1:0] mem [1 << MEM_AW];
  logic [MEM_AW-1:0]     commit_idx;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [MASK_W-1:0]     commit_mask;

  logic [RD_LATENCY-2:0] pv;
  logic [DATA_WIDTH-1:0] pd [RD_LATENCY-1];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WQ_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Only the word-index bits of addr select RAM; the rest alias.
  assign addr_unused = ^{addr[ADDR_WIDTH-1:MEM_AW+3], addr[2:0]};

  // Handshakes: a command transfers on cmd_en & cmd_ready with a legal cmd,
  // a write beat on wr_data_en & wr_data_rdy & wr_data_end; anything else
  // offered on a strobe is dropped and flags protocol_err.
  assign wcmd_full  = (wcmd_cnt == CW'(WQ_DEPTH));
  assign wcmd_empty = (wcmd_cnt == '0);
  assign wdat_full  = (wdat_cnt == CW'(WQ_DEPTH));

  assign cmd_ready   = (state == ST_IDLE) & init_calib_complete & ~wcmd_full;
  assign wr_data_rdy = init_calib_complete & ~wdat_full;

  assign cmd_ok  = (cmd == 3'b000) | (cmd == 3'b001);
  assign cmd_acc = cmd_en & cmd_ready & cmd_ok;
  assign wr_acc  = cmd_acc & (cmd == 3'b000);
  assign rd_acc  = cmd_acc & (cmd == 3'b001);
  assign wd_acc  = wr_data_en & wr_data_rdy & wr_data_end;
  assign commit  = ~wcmd_empty & (wdat_cnt != '0);
  assign launch  = (state == ST_RD_WAIT) & wcmd_empty;

  assign err_now = (cmd_en & ~cmd_ready) | (cmd_en & ~cmd_ok) |
                   (wr_data_en & ~wr_data_rdy) | (wr_data_en != wr_data_end);

  assign ref_tick = init_calib_complete & (ref_cnt == REF_W'(REF_INTERVAL - 1));
  assign ref_req  = ref_tick | ref_pend;

  // A read in flight holds off refresh until it has launched.
  always_comb begin
    state_nxt    = state;
    ref_pend_nxt = ref_pend | ref_tick;
    case (state)
      ST_IDLE: begin
        if (rd_acc) begin
          state_nxt = ST_RD_WAIT;
        end else if (ref_req) begin
          state_nxt    = ST_REFRESH;
          ref_pend_nxt = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        if (launch) begin
          if (ref_req) begin
            state_nxt    = ST_REFRESH;
            ref_pend_nxt = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_REFRESH: begin
        if (ref_cyc == RC_W'(REF_CYCLES - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      ref_pend            <= 1'b0;
      ref_cyc             <= '0;
      ref_cnt             <= '0;
      calib_cnt           <= '0;
      init_calib_complete <= 1'b0;
      rd_idx              <= '0;
      protocol_err        <= 1'b0;
    end else begin
      state    <= state_nxt;
      ref_pend <= ref_pend_nxt;
      ref_cyc  <= (state == ST_REFRESH) ? ref_cyc + RC_W'(1) : '0;
      if (!init_calib_complete) begin
        if (calib_cnt == CAL_W'(CALIB_CYCLES - 1)) init_calib_complete <= 1'b1;
        else calib_cnt <= calib_cnt + CAL_W'(1);
      end
      if (!init_calib_complete || ref_tick) ref_cnt <= '0;
      else ref_cnt <= ref_cnt + REF_W'(1);
      if (rd_acc) rd_idx <= addr[MEM_AW+2:3];
      if (err_now) protocol_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcmd_wptr <= '0;
      wcmd_rptr <= '0;
      wcmd_cnt  <= '0;
      wdat_wptr <= '0;
      wdat_rptr <= '0;
      wdat_cnt  <= '0;
    end else begin
      if (wr_acc) wcmd_wptr <= ptr_inc(wcmd_wptr);
      if (wd_acc) wdat_wptr <= ptr_inc(wdat_wptr);
      if (commit) begin
        wcmd_rptr <= ptr_inc(wcmd_rptr);
        wdat_rptr <= ptr_inc(wdat_rptr);
      end
      wcmd_cnt <= wcmd_cnt + CW'(wr_acc) - CW'(commit);
      wdat_cnt <= wdat_cnt + CW'(wd_acc) - CW'(commit);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) wcmd_mem[wcmd_wptr] <= addr[MEM_AW+2:3];
    if (wd_acc) begin
      wdat_mem[wdat_wptr]  <= wr_data;
      wmask_mem[wdat_wptr] <= wr_data_mask;
    end
  end

  assign commit_idx  = wcmd_mem[wcmd_rptr];
  assign commit_data = wdat_mem[wdat_rptr];
  assign commit_mask = wmask_mem[wdat_rptr];

  // Mask bit set means the byte keeps its old contents.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (!commit_mask[i]) mem[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    pd[0] <= mem[rd_idx];
    for (int k = 1; k < RD_LATENCY - 1; k++) pd[k] <= pd[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv            <= '0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      pv[0] <= launch;
      for (int k = 1; k < RD_LATENCY - 1; k++) pv[k] <= pv[k-1];
      rd_data_valid <= pv[RD_LATENCY-2];
      if (pv[RD_LATENCY-2]) rd_data <= pd[RD_LATENCY-2];
    end
  end

  assign rd_data_end = rd_data_valid;

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Directed bench for ddr3_app_responder: read responses are checked against
// an expected queue filled as read commands are driven.
module tb_ddr3_app_responder;

  localparam int AW = 29;
  localparam int DW = 256;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd = '0;
  logic          cmd_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          wr_data_rdy;
  logic [DW-1:0] wr_data = '0;
  logic          wr_data_en = 1'b0;
  logic          wr_data_end = 1'b0;
  logic [MW-1:0] wr_data_mask = '0;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          rd_data_end;
  logic          init_calib_complete;
  logic          protocol_err;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_model [int];

  ddr3_app_responder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_ready           (cmd_ready),
    .cmd                 (cmd),
    .cmd_en              (cmd_en),
    .addr                (addr),
    .wr_data_rdy         (wr_data_rdy),
    .wr_data             (wr_data),
    .wr_data_en          (wr_data_en),
    .wr_data_end         (wr_data_end),
    .wr_data_mask        (wr_data_mask),
    .rd_data             (rd_data),
    .rd_data_valid       (rd_data_valid),
    .rd_data_end         (rd_data_end),
    .init_calib_complete (init_calib_complete),
    .protocol_err        (protocol_err)
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every response pops the oldest expected word
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_data_valid) begin
        check("rd_q_nonempty", DW'(exp_q.size() != 0), DW'(1));
        if (exp_q.size() != 0) check("rd_data", rd_data, exp_q.pop_front());
        check("rd_end_hi", DW'(rd_data_end), DW'(1));
      end else begin
        check("rd_end_lo", DW'(rd_data_end), DW'(0));
      end
    end
  end

  task automatic send_cmd(input logic [2:0] c, input int idx);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_wait", DW'(cmd_ready), DW'(1));
    cmd    = c;
    addr   = AW'(idx * 8);
    cmd_en = 1'b1;
    @(negedge clk);
    cmd_en = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] d, input logic [MW-1:0] m);
    int n;
    n = 0;
    @(negedge clk);
    while (!wr_data_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wd_wait", DW'(wr_data_rdy), DW'(1));
    wr_data      = d;
    wr_data_mask = m;
    wr_data_en   = 1'b1;
    wr_data_end  = 1'b1;
    @(negedge clk);
    wr_data_en   = 1'b0;
    wr_data_end  = 1'b0;
  endtask

  task automatic write_word(input int idx, input logic [DW-1:0] d);
    send_cmd(3'b000, idx);
    send_data(d, '0);
    mem_model[idx] = d;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int n;
    int lows;
    int run;
    int max_run;
    int k;
    int vcnt;
    logic [DW-1:0] d [5];
    logic [DW-1:0] a5;
    logic [DW-1:0] mask_exp;

    a5       = {32{8'hA5}};
    mask_exp = {224'd0, 32'hFFFF_FFFF};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", DW'(rd_data_valid), DW'(0));
    check("rst_end", DW'(rd_data_end), DW'(0));
    check("rst_cmd_ready", DW'(cmd_ready), DW'(0));
    check("rst_wd_rdy", DW'(wr_data_rdy), DW'(0));
    check("rst_calib", DW'(init_calib_complete), DW'(0));
    check("rst_err", DW'(protocol_err), DW'(0));
    check("rst_rd_data", rd_data, '0);

    // calibration
    rst_n = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      check("calib", DW'(init_calib_complete), DW'(c >= 64));
      if (c == 63) begin
        check("calib_cmd_ready_lo", DW'(cmd_ready), DW'(0));
        check("calib_wd_rdy_lo", DW'(wr_data_rdy), DW'(0));
      end
      if (c == 64) begin
        check("calib_cmd_ready_hi", DW'(cmd_ready), DW'(1));
        check("calib_wd_rdy_hi", DW'(wr_data_rdy), DW'(1));
      end
    end
    check("calib_err", DW'(protocol_err), DW'(0));

    // write 0x40 with data one cycle later, then read it back
    cmd = 3'b000; addr = AW'('h40); cmd_en = 1'b1;
    @(negedge clk);
    cmd_en = 1'b0;
    wr_data = a5; wr_data_mask = '0; wr_data_en = 1'b1; wr_data_end = 1'b1;
    @(negedge clk);
    wr_data_en = 1'b0; wr_data_end = 1'b0;
    mem_model[8] = a5;
    check("wr_rd_ready", DW'(cmd_ready), DW'(1));
    exp_q.push_back(a5);
    cmd = 3'b001; addr = AW'('h40); cmd_en = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      cmd_en = 1'b0;
      check("rd_latency_valid", DW'(rd_data_valid), DW'(c == 5));
    end
    check("rd_hold", rd_data, a5);

    // byte mask
    write_word(16, '1);
    send_cmd(3'b000, 16);
    send_data('0, 32'h0000_000F);
    mem_model[16] = mask_exp;
    exp_q.push_back(mask_exp);
    send_cmd(3'b001, 16);
    repeat (8) @(negedge clk);

    // write-command backpressure
    for (int i = 0; i < 5; i++) d[i] = rand_word();
    for (int i = 0; i < 4; i++) send_cmd(3'b000, 40 + i);
    check("bp_full", DW'(cmd_ready), DW'(0));
    check("bp_wd_rdy", DW'(wr_data_rdy), DW'(1));
    wr_data = d[0]; wr_data_mask = '0; wr_data_en = 1'b1; wr_data_end = 1'b1;
    @(negedge clk);
    wr_data_en = 1'b0; wr_data_end = 1'b0;
    check("bp_still_full", DW'(cmd_ready), DW'(0));
    @(negedge clk);
    check("bp_released", DW'(cmd_ready), DW'(1));
    send_cmd(3'b000, 44);
    for (int i = 1; i < 5; i++) send_data(d[i], '0);
    for (int i = 0; i < 5; i++) begin
      mem_model[40 + i] = d[i];
      exp_q.push_back(d[i]);
      send_cmd(3'b001, 40 + i);
    end
    repeat (10) @(negedge clk);

    // first refresh with an idle port: stall starts 780 cycles after calib
    while (edge_cnt < 835) @(negedge clk);
    lows = 0;
    while (edge_cnt < 870) begin
      @(negedge clk);
      if (edge_cnt == 843) check("ref_before", DW'(cmd_ready), DW'(1));
      if (edge_cnt == 844) check("ref_first", DW'(cmd_ready), DW'(0));
      if (edge_cnt == 859) check("ref_last", DW'(cmd_ready), DW'(0));
      if (edge_cnt == 860) check("ref_after", DW'(cmd_ready), DW'(1));
      if (!cmd_ready) lows++;
    end
    check("ref_len", DW'(lows), DW'(16));
    check("ref_wd_rdy", DW'(wr_data_rdy), DW'(1));

    // read stream across the second refresh
    for (int i = 0; i < 8; i++) write_word(32 + i, rand_word());
    while (edge_cnt < 1595) @(negedge clk);
    k = 0; run = 0; max_run = 0;
    while (edge_cnt < 1665) begin
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back(mem_model[32 + (k % 8)]);
        cmd = 3'b001; addr = AW'((32 + (k % 8)) * 8); cmd_en = 1'b1;
        k++;
        run = 0;
      end else begin
        cmd_en = 1'b0;
        run++;
        if (run > max_run) max_run = run;
      end
    end
    @(negedge clk);
    cmd_en = 1'b0;
    repeat (12) @(negedge clk);
    check("stream_stall", DW'(max_run >= 16 && max_run <= 17), DW'(1));
    check("stream_drained", DW'(exp_q.size()), DW'(0));
    check("stream_err", DW'(protocol_err), DW'(0));

    // illegal command
    check("ill_ready", DW'(cmd_ready), DW'(1));
    cmd = 3'b010; addr = '0; cmd_en = 1'b1;
    @(negedge clk);
    cmd_en = 1'b0; cmd = 3'b000;
    check("ill_err", DW'(protocol_err), DW'(1));
    check("ill_dropped", DW'(cmd_ready), DW'(1));
    repeat (5) @(negedge clk);
    check("ill_sticky", DW'(protocol_err), DW'(1));

    // reset while a second read is still in flight
    exp_q.push_back(mem_model[32]);
    send_cmd(3'b001, 32);
    send_cmd(3'b001, 33);
    n = 0;
    while (!rd_data_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_valid", DW'(rd_data_valid), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", DW'(rd_data_valid), DW'(0));
    check("mid_rst_end", DW'(rd_data_end), DW'(0));
    check("mid_rst_err", DW'(protocol_err), DW'(0));
    check("mid_rst_calib", DW'(init_calib_complete), DW'(0));
    check("mid_rst_ready", DW'(cmd_ready), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd_data_valid) vcnt++;
    end
    check("mid_flushed", DW'(vcnt), DW'(0));
    check("final_q_empty", DW'(exp_q.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
